// File: rtl/jts16_obj_pkg.sv
// Shared types and constants for the object line scanner.
package jts16_obj_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    XPOS,
    PITCH,
    OFFS,
    ATTR,
    WB,
    ISSUE
  } state_t;

  // Word indices within one 8-word object table entry
  localparam logic [2:0] W_HDR   = 3'd0;
  localparam logic [2:0] W_XPOS  = 3'd1;
  localparam logic [2:0] W_PITCH = 3'd2;
  localparam logic [2:0] W_OFFS  = 3'd3;
  localparam logic [2:0] W_ATTR  = 3'd4;
  localparam logic [2:0] W_RUN   = 3'd7;

  localparam logic [7:0] END_MARK = 8'hF0;

endpackage

// File: rtl/jts16_obj_zone.sv
// Decodes an object header word {bottom,top} against the line being scanned.
module jts16_obj_zone
  import jts16_obj_pkg::*;
(
  input  logic [15:0] hdr,
  input  logic [7:0]  vline,
  output logic        last_c,
  output logic        bad_c,
  output logic        hit_c,
  output logic        first_c
);

  logic [7:0] top;
  logic [7:0] bottom;

  assign top     = hdr[7:0];
  assign bottom  = hdr[15:8];
  assign last_c  = bottom >= END_MARK;
  assign bad_c   = top >= bottom;
  assign hit_c   = (vline >= top) && (vline < bottom);
  assign first_c = vline == top;

endmodule

// File: rtl/jts16_obj_linescan.sv
// Walks the object table for one line and issues in-zone objects to the drawer.
// Optional per-line issue limit enabled by defining JTS16_OBJ_LIMIT_EN.
module jts16_obj_linescan
  import jts16_obj_pkg::*;
#(
  parameter int unsigned OBJW    = 7,
  parameter int unsigned BANKW   = 3,
  parameter logic [8:0]  PXL_DLY = 9'd8,
  parameter logic [8:0]  VLAST   = 9'd223,
  parameter int unsigned LIMIT   = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OBJW+2:0]  tbl_addr,
  input  logic [15:0]      tbl_dout,
  output logic [15:0]      tbl_din,
  output logic             tbl_we,
  output logic             dr_start,
  input  logic             dr_busy,
  output logic [8:0]       dr_xpos,
  output logic [15:0]      dr_offset,
  output logic [BANKW-1:0] dr_bank,
  output logic [1:0]       dr_prio,
  output logic [5:0]       dr_pal,
  input  logic             hstart,
  input  logic [8:0]       vrender,
  output logic             obj_ovf,
  output logic             scan_done
);

`ifdef JTS16_OBJ_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  state_t            state;
  logic              wt;
  logic [OBJW-1:0]   obj;
  logic [OBJW-1:0]   obj_nx;
  logic              obj_last;
  logic [31:0]       cnt;
  logic              ovf;
  logic              first;
  logic [8:0]        xpos;
  logic [15:0]       pitch;
  logic [15:0]       run;
  logic [15:0]       cur;
  logic [5:0]        pal_q;
  logic [BANKW-1:0]  bank_q;
  logic [1:0]        prio_q;
  logic              z_last;
  logic              z_bad;
  logic              z_hit;
  logic              z_first;

  assign obj_nx   = obj + OBJW'(1);
  assign obj_last = &obj;
  assign obj_ovf  = LIMIT_EN ? ovf : 1'b0;

  jts16_obj_zone u_zone (
    .hdr     (tbl_dout),
    .vline   (vrender[7:0]),
    .last_c  (z_last),
    .bad_c   (z_bad),
    .hit_c   (z_hit),
    .first_c (z_first)
  );

  // Every read state spends one cycle letting the registered RAM catch up (wt)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wt        <= 1'b0;
      obj       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      first     <= 1'b0;
      xpos      <= '0;
      pitch     <= '0;
      run       <= '0;
      cur       <= '0;
      pal_q     <= '0;
      bank_q    <= '0;
      prio_q    <= '0;
      tbl_addr  <= '0;
      tbl_din   <= '0;
      tbl_we    <= 1'b0;
      dr_start  <= 1'b0;
      dr_xpos   <= '0;
      dr_offset <= '0;
      dr_bank   <= '0;
      dr_prio   <= '0;
      dr_pal    <= '0;
      scan_done <= 1'b1;
    end else begin
      dr_start <= 1'b0;
      tbl_we   <= 1'b0;
      if (hstart) begin
        wt <= 1'b0;
        if (vrender <= VLAST) begin
          state     <= HDR;
          wt        <= 1'b1;
          obj       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
          scan_done <= 1'b0;
          tbl_addr  <= {OBJW'(0), W_HDR};
        end else begin
          state     <= IDLE;
          scan_done <= 1'b1;
        end
      end else if (wt) begin
        wt <= 1'b0;
      end else begin
        case (state)
          HDR: begin
            if (z_last) begin
              state     <= IDLE;
              scan_done <= 1'b1;
            end else if (z_bad || !z_hit) begin
              if (obj_last) begin
                state     <= IDLE;
                scan_done <= 1'b1;
              end else begin
                obj      <= obj_nx;
                tbl_addr <= {obj_nx, W_HDR};
                wt       <= 1'b1;
              end
            end else if (LIMIT_EN && (cnt >= LIMIT)) begin
              ovf       <= 1'b1;
              state     <= IDLE;
              scan_done <= 1'b1;
            end else begin
              first    <= z_first;
              tbl_addr <= {obj, W_XPOS};
              wt       <= 1'b1;
              state    <= XPOS;
            end
          end
          XPOS: begin
            xpos     <= tbl_dout[8:0];
            tbl_addr <= {obj, W_PITCH};
            wt       <= 1'b1;
            state    <= PITCH;
          end
          PITCH: begin
            pitch    <= tbl_dout;
            tbl_addr <= {obj, first ? W_OFFS : W_RUN};
            wt       <= 1'b1;
            state    <= OFFS;
          end
          // Offset drawn now, and the one the next line starts from
          OFFS: begin
            cur      <= tbl_dout;
            run      <= tbl_dout + pitch;
            tbl_addr <= {obj, W_ATTR};
            wt       <= 1'b1;
            state    <= ATTR;
          end
          ATTR: begin
            pal_q    <= tbl_dout[13:8];
            bank_q   <= tbl_dout[4 +: BANKW];
            prio_q   <= tbl_dout[1:0];
            tbl_addr <= {obj, W_RUN};
            tbl_din  <= run;
            tbl_we   <= 1'b1;
            state    <= WB;
          end
          WB: begin
            state <= ISSUE;
          end
          ISSUE: begin
            if (!dr_busy) begin
              dr_xpos   <= xpos + PXL_DLY;
              dr_offset <= cur;
              dr_bank   <= bank_q;
              dr_prio   <= prio_q;
              dr_pal    <= pal_q;
              dr_start  <= 1'b1;
              cnt       <= cnt + 32'd1;
              if (obj_last) begin
                state     <= IDLE;
                scan_done <= 1'b1;
              end else begin
                obj      <= obj_nx;
                tbl_addr <= {obj_nx, W_HDR};
                wt       <= 1'b1;
                state    <= HDR;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jts16_obj_linescan.sv
// Directed bench for jts16_obj_linescan with a registered table RAM model.
module tb_jts16_obj_linescan;

  localparam int unsigned OBJW  = 7;
  localparam int unsigned BANKW = 3;
  localparam int unsigned AW    = OBJW + 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    tbl_addr;
  logic [15:0]      tbl_dout;
  logic [15:0]      tbl_din;
  logic             tbl_we;
  logic             dr_start;
  logic             dr_busy;
  logic [8:0]       dr_xpos;
  logic [15:0]      dr_offset;
  logic [BANKW-1:0] dr_bank;
  logic [1:0]       dr_prio;
  logic [5:0]       dr_pal;
  logic             hstart;
  logic [8:0]       vrender;
  logic             obj_ovf;
  logic             scan_done;

  logic [15:0]   mem [0:(1<<AW)-1];
  logic          hwe;
  logic [AW-1:0] haddr;
  logic [15:0]   hdata;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int wes    = 0;

  always #5 clk = ~clk;

  jts16_obj_linescan #(
    .OBJW(OBJW), .BANKW(BANKW), .PXL_DLY(9'd8), .VLAST(9'd223), .LIMIT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .tbl_addr(tbl_addr), .tbl_dout(tbl_dout), .tbl_din(tbl_din), .tbl_we(tbl_we),
    .dr_start(dr_start), .dr_busy(dr_busy), .dr_xpos(dr_xpos), .dr_offset(dr_offset),
    .dr_bank(dr_bank), .dr_prio(dr_prio), .dr_pal(dr_pal),
    .hstart(hstart), .vrender(vrender), .obj_ovf(obj_ovf), .scan_done(scan_done)
  );

  // Registered RAM: DUT write port has priority over the bench loader
  always @(posedge clk) begin
    if (tbl_we) mem[tbl_addr] <= tbl_din;
    else if (hwe) mem[haddr] <= hdata;
    tbl_dout <= mem[tbl_addr];
  end

  always @(negedge clk) begin
    if (dr_start) starts <= starts + 1;
    if (tbl_we) wes <= wes + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int unsigned o, input int unsigned w, input logic [15:0] d);
    @(negedge clk);
    haddr = AW'(o * 8 + w);
    hdata = d;
    hwe   = 1'b1;
    @(negedge clk);
    hwe   = 1'b0;
  endtask

  task automatic put_obj(input int unsigned o, input logic [7:0] top, input logic [7:0] bottom,
                         input logic [15:0] x, input logic [15:0] pitch,
                         input logic [15:0] offs, input logic [15:0] attr);
    wr(o, 0, {bottom, top});
    wr(o, 1, x);
    wr(o, 2, pitch);
    wr(o, 3, offs);
    wr(o, 4, attr);
  endtask

  task automatic wait_done(input int unsigned budget, output int unsigned cyc);
    cyc = 0;
    while (!scan_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("scan_done_timeout", 32'(scan_done), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_line(input logic [8:0] v, input int unsigned budget, output int unsigned cyc);
    @(negedge clk);
    vrender = v;
    hstart  = 1'b1;
    @(negedge clk);
    hstart  = 1'b0;
    wait_done(budget, cyc);
  endtask

  initial begin
    int unsigned cyc;
    int s0;
    int e0;
    bit seen;
    hwe = 1'b0; haddr = '0; hdata = '0;
    hstart = 1'b0; vrender = '0; dr_busy = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_scan_done", 32'(scan_done), 32'd1);
    check("rst_dr_start", 32'(dr_start), 32'd0);
    check("rst_tbl_we", 32'(tbl_we), 32'd0);
    check("rst_dr_xpos", 32'(dr_xpos), 32'd0);
    check("rst_dr_offset", 32'(dr_offset), 32'd0);
    check("rst_dr_attr", 32'({dr_pal, dr_bank, dr_prio}), 32'd0);
    check("rst_obj_ovf", 32'(obj_ovf), 32'd0);
    rst = 1'b0;

    // First line of obj0
    put_obj(0, 8'd10, 8'd20, 16'h0050, 16'd4, 16'h0100, 16'h2A52);
    wr(1, 0, 16'hF000);
    s0 = starts; e0 = wes;
    run_line(9'd10, 200, cyc);
    check("first_starts", 32'(starts - s0), 32'd1);
    check("first_offset", 32'(dr_offset), 32'h0100);
    check("first_xpos", 32'(dr_xpos), 32'h058);
    check("first_pal", 32'(dr_pal), 32'h2A);
    check("first_bank", 32'(dr_bank), 32'd5);
    check("first_prio", 32'(dr_prio), 32'd2);
    check("first_w7", 32'(mem[7]), 32'h0104);
    check("first_we_count", 32'(wes - e0), 32'd1);

    // Continuation line uses w7
    run_line(9'd11, 200, cyc);
    check("cont_offset", 32'(dr_offset), 32'h0104);
    check("cont_w7", 32'(mem[7]), 32'h0108);

    // Negative pitch and xpos wrap
    wr(0, 1, 16'h01FC);
    wr(0, 2, 16'hFFFC);
    wr(0, 7, 16'h0104);
    run_line(9'd11, 200, cyc);
    check("neg_offset", 32'(dr_offset), 32'h0104);
    check("neg_w7", 32'(mem[7]), 32'h0100);
    check("xpos_wrap", 32'(dr_xpos), 32'h004);

    // Line == bottom is outside the zone
    s0 = starts;
    run_line(9'd20, 200, cyc);
    check("bottom_no_start", 32'(starts - s0), 32'd0);
    check("bottom_w7_kept", 32'(mem[7]), 32'h0100);

    // Last line inside the zone
    run_line(9'd19, 200, cyc);
    check("last_in_offset", 32'(dr_offset), 32'h0100);
    check("last_in_w7", 32'(mem[7]), 32'h00FC);

    // End marker in obj0
    wr(0, 0, 16'hF000);
    s0 = starts;
    run_line(9'd10, 200, cyc);
    check("end_no_start", 32'(starts - s0), 32'd0);
    check("end_fast", 32'(cyc <= 3), 32'd1);
    check("end_hold_offset", 32'(dr_offset), 32'h0100);

    // Skips: obj0 empty zone, obj1 out of zone, obj2 issues
    put_obj(0, 8'd20, 8'd20, 16'h0000, 16'd0, 16'h0000, 16'h0000);
    wr(0, 7, 16'hDEAD);
    put_obj(1, 8'd50, 8'd60, 16'h0000, 16'd0, 16'h0000, 16'h0000);
    wr(1, 7, 16'hBEEF);
    put_obj(2, 8'd5, 8'd30, 16'h0100, 16'd2, 16'h0200, 16'h0001);
    wr(3, 0, 16'hF000);
    s0 = starts; e0 = wes;
    run_line(9'd5, 300, cyc);
    check("skip_starts", 32'(starts - s0), 32'd1);
    check("skip_offset", 32'(dr_offset), 32'h0200);
    check("skip_xpos", 32'(dr_xpos), 32'h108);
    check("skip_attr", 32'({dr_pal, dr_bank, dr_prio}), 32'd1);
    check("skip_w7_obj0", 32'(mem[7]), 32'hDEAD);
    check("skip_w7_obj1", 32'(mem[15]), 32'hBEEF);
    check("skip_w7_obj2", 32'(mem[23]), 32'h0202);
    check("skip_we_count", 32'(wes - e0), 32'd1);

    // Busy drawer then hstart aborts the pending object
    put_obj(0, 8'd40, 8'd50, 16'h0020, 16'd16, 16'h0300, 16'h0133);
    wr(1, 0, 16'hF000);
    dr_busy = 1'b1;
    s0 = starts;
    @(negedge clk); vrender = 9'd40; hstart = 1'b1;
    @(negedge clk); hstart = 1'b0;
    repeat (50) @(negedge clk);
    check("busy_hold_starts", 32'(starts - s0), 32'd0);
    check("busy_hold_active", 32'(scan_done), 32'd0);
    hstart = 1'b1; dr_busy = 1'b0;
    @(negedge clk); hstart = 1'b0;
    check("abort_no_start", 32'(dr_start), 32'd0);
    check("rescan_addr", 32'(tbl_addr), 32'd0);
    check("rescan_active", 32'(scan_done), 32'd0);
    wait_done(200, cyc);
    check("rescan_starts", 32'(starts - s0), 32'd1);
    check("rescan_offset", 32'(dr_offset), 32'h0300);
    check("rescan_xpos", 32'(dr_xpos), 32'h028);
    check("rescan_attr", 32'({dr_pal, dr_bank, dr_prio}), 32'({6'd1, 3'd3, 2'd3}));
    check("rescan_w7", 32'(mem[7]), 32'h0310);

    // hstart beyond the last active line, mid-scan and while idle
    dr_busy = 1'b1;
    s0 = starts;
    @(negedge clk); vrender = 9'd41; hstart = 1'b1;
    @(negedge clk); hstart = 1'b0;
    repeat (20) @(negedge clk);
    vrender = 9'd230; hstart = 1'b1;
    @(negedge clk); hstart = 1'b0;
    check("vblank_done", 32'(scan_done), 32'd1);
    dr_busy = 1'b0;
    repeat (20) @(negedge clk);
    run_line(9'd230, 10, cyc);
    check("vblank_no_start", 32'(starts - s0), 32'd0);

    // Reset during the write-back cycle
    s0 = starts;
    @(negedge clk); vrender = 9'd41; hstart = 1'b1;
    @(negedge clk); hstart = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = tbl_we;
    end
    check("we_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_we", 32'(tbl_we), 32'd0);
    check("rst_mid_done", 32'(scan_done), 32'd1);
    check("rst_mid_offset", 32'(dr_offset), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_no_start", 32'(starts - s0), 32'd0);

    // Three in-zone objects against the per-line limit
    put_obj(0, 8'd60, 8'd70, 16'h0010, 16'd1, 16'h1000, 16'h0000);
    put_obj(1, 8'd60, 8'd70, 16'h0020, 16'd1, 16'h2000, 16'h0000);
    put_obj(2, 8'd60, 8'd70, 16'h0030, 16'd1, 16'h3000, 16'h0000);
    wr(2, 7, 16'h7777);
    wr(3, 0, 16'hF000);
    s0 = starts;
    run_line(9'd60, 300, cyc);
`ifdef JTS16_OBJ_LIMIT_EN
    check("limit_starts", 32'(starts - s0), 32'd2);
    check("limit_ovf", 32'(obj_ovf), 32'd1);
    check("limit_w7_obj2", 32'(mem[23]), 32'h7777);
    check("limit_offset", 32'(dr_offset), 32'h2000);
`else
    check("nolimit_starts", 32'(starts - s0), 32'd3);
    check("nolimit_ovf", 32'(obj_ovf), 32'd0);
    check("nolimit_w7_obj2", 32'(mem[23]), 32'h3001);
    check("nolimit_offset", 32'(dr_offset), 32'h3000);
`endif
    run_line(9'd75, 300, cyc);
    check("ovf_cleared", 32'(obj_ovf), 32'd0);

    // No end marker anywhere: scan ends when the index wraps
    for (int i = 0; i < 128; i++) wr(i, 0, 16'h0000);
    s0 = starts;
    run_line(9'd10, 600, cyc);
    check("wrap_no_start", 32'(starts - s0), 32'd0);
    check("wrap_took_all", 32'(cyc >= 128), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
